// File: rtl/sr_coproc_seq_pkg.sv
// rtl/sr_coproc_seq_pkg.sv - shared types and constants for the coprocessor sequencer
// Purpose: sequencer state encoding, default mode width, write-back source code
//          and a small elaboration helper.
// Ports:   none (package).
package sr_coproc_seq_pkg;

    localparam int MODE_W_DEF = 21;

    // Write-back mux select code used by sr_control for the coprocessor result.
    localparam logic [1:0] WD_SRC_CRYPT = 2'd3;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_ISSUE = 3'd1,
        SEQ_WAIT  = 3'd2,
        SEQ_WB    = 3'd3,
        SEQ_ERR   = 3'd4
    } seq_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_coproc_timer.sv
// rtl/sr_coproc_timer.sv - clearable saturating counter with terminal-count compare
// Purpose: shared cycle counter for the latency and timeout paths.
// Ports:   clk, rst (sync, active-high); clr clears, inc increments (clr wins);
//          tc_val terminal value; tc = counter equals tc_val.
module sr_coproc_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            // Saturate instead of wrapping so a stuck request can never alias
            // back onto the terminal count.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/sr_coproc_seq.sv
// rtl/sr_coproc_seq.sv - multi-cycle coprocessor request/complete sequencer
// Purpose: latches operands and mode, handshakes with the coprocessor, waits for
//          completion (done strobe or fixed latency, with watchdog), buffers the
//          result and drives stall / write-back / control-select to the datapath.
// Ports:   clk, rst (sync, active-high); crypt_instr, crypt_mode, rd1, rd2 from decode;
//          select_comb_ctrls, hold, regWrite, wd_crypt, seq_err to the datapath;
//          cop_valid/cop_ready, cop_mode, cop_op1, cop_op2 request side;
//          cop_done, cop_result completion side.
module sr_coproc_seq
    import sr_coproc_seq_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MODE_W   = MODE_W_DEF,
    parameter int USE_DONE = 1,
    parameter int LATENCY  = 1,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              crypt_instr,
    input  logic [MODE_W-1:0] crypt_mode,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    output logic              select_comb_ctrls,
    output logic              hold,
    output logic              regWrite,
    output logic [XLEN-1:0]   wd_crypt,
    output logic              seq_err,
    output logic              cop_valid,
    input  logic              cop_ready,
    output logic [MODE_W-1:0] cop_mode,
    output logic [XLEN-1:0]   cop_op1,
    output logic [XLEN-1:0]   cop_op2,
    input  logic              cop_done,
    input  logic [XLEN-1:0]   cop_result
);

    generate
        if ((LATENCY < 1) || (TIMEOUT < 2) ||
            (max2(LATENCY, TIMEOUT) > (2 ** CNT_W) - 1)) begin : g_bad_cfg
            $error("sr_coproc_seq: LATENCY/TIMEOUT out of range for CNT_W");
        end
    endgenerate

    // One counter serves both modes: it measures WAIT length when finishing on
    // latency, and acts as the watchdog when finishing on cop_done.
    localparam logic [CNT_W-1:0] TC_VAL =
        CNT_W'((USE_DONE != 0) ? (TIMEOUT - 1) : (LATENCY - 1));

    seq_state_e        state_q, state_d;
    logic [MODE_W-1:0] cop_mode_q, cop_mode_d;
    logic [XLEN-1:0]   cop_op1_q, cop_op1_d;
    logic [XLEN-1:0]   cop_op2_q, cop_op2_d;
    logic [XLEN-1:0]   wd_crypt_q, wd_crypt_d;
    logic              cnt_clr, cnt_inc, cnt_tc;

    sr_coproc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .tc_val (TC_VAL),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            cop_mode_q <= '0;
            cop_op1_q  <= '0;
            cop_op2_q  <= '0;
            wd_crypt_q <= '0;
        end else begin
            state_q    <= state_d;
            cop_mode_q <= cop_mode_d;
            cop_op1_q  <= cop_op1_d;
            cop_op2_q  <= cop_op2_d;
            wd_crypt_q <= wd_crypt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cop_mode_d = cop_mode_q;
        cop_op1_d  = cop_op1_q;
        cop_op2_d  = cop_op2_q;
        wd_crypt_d = wd_crypt_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (crypt_instr) begin
                    cop_mode_d = crypt_mode;
                    cop_op1_d  = rd1;
                    cop_op2_d  = rd2;
                    cnt_clr    = 1'b1;
                    state_d    = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (cop_ready) begin
                    cnt_clr = 1'b1;
                    state_d = SEQ_WAIT;
                end else if ((USE_DONE != 0) && cnt_tc) begin
                    state_d = SEQ_ERR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SEQ_WAIT: begin
                if (USE_DONE != 0) begin
                    // Done is tested first so it wins over the final watchdog cycle.
                    if (cop_done) begin
                        wd_crypt_d = cop_result;
                        state_d    = SEQ_WB;
                    end else if (cnt_tc) begin
                        state_d = SEQ_ERR;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else begin
                    if (cnt_tc) begin
                        wd_crypt_d = cop_result;
                        state_d    = SEQ_WB;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            SEQ_WB:  state_d = SEQ_IDLE;
            SEQ_ERR: state_d = SEQ_IDLE;
            default: state_d = SEQ_IDLE;
        endcase
    end

    // hold/select follow crypt_instr combinationally in IDLE so the stall starts
    // in the decode cycle; everything else is a decode of registered state.
    always_comb begin
        hold              = 1'b0;
        select_comb_ctrls = 1'b0;
        cop_valid         = 1'b0;
        regWrite          = 1'b0;
        seq_err           = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                hold              = crypt_instr;
                select_comb_ctrls = ~crypt_instr;
            end
            SEQ_ISSUE: begin
                hold      = 1'b1;
                cop_valid = 1'b1;
            end
            SEQ_WAIT: hold     = 1'b1;
            SEQ_WB:   regWrite = 1'b1;
            SEQ_ERR:  seq_err  = 1'b1;
            default: begin
                hold              = 1'b0;
                select_comb_ctrls = 1'b0;
            end
        endcase
    end

    assign cop_mode = cop_mode_q;
    assign cop_op1  = cop_op1_q;
    assign cop_op2  = cop_op2_q;
    assign wd_crypt = wd_crypt_q;

endmodule

// File: tb/tb_sr_coproc_seq.sv
// tb/tb_sr_coproc_seq.sv - self-checking bench for sr_coproc_seq
module tb_sr_coproc_seq;

    localparam int XLEN   = 32;
    localparam int MODE_W = 21;
    localparam int PL_W   = MODE_W + 2 * XLEN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: fixed latency (USE_DONE=0, LATENCY=1), ready tied high.
    logic              i0_instr, i0_done;
    logic [MODE_W-1:0] i0_mode;
    logic [XLEN-1:0]   i0_rd1, i0_rd2, i0_result;
    logic              o0_sel, o0_hold, o0_rw, o0_err, o0_valid;
    logic [XLEN-1:0]   o0_wd, o0_op1, o0_op2;
    logic [MODE_W-1:0] o0_mode;

    // Instance 1: done-terminated with TIMEOUT=4.
    logic              i1_instr, i1_done, i1_ready;
    logic [MODE_W-1:0] i1_mode;
    logic [XLEN-1:0]   i1_rd1, i1_rd2, i1_result;
    logic              o1_sel, o1_hold, o1_rw, o1_err, o1_valid;
    logic [XLEN-1:0]   o1_wd, o1_op1, o1_op2;
    logic [MODE_W-1:0] o1_mode;

    sr_coproc_seq #(.XLEN(XLEN), .MODE_W(MODE_W), .USE_DONE(0), .LATENCY(1),
                    .TIMEOUT(16), .CNT_W(5)) dut0 (
        .clk(clk), .rst(rst), .crypt_instr(i0_instr), .crypt_mode(i0_mode),
        .rd1(i0_rd1), .rd2(i0_rd2), .select_comb_ctrls(o0_sel), .hold(o0_hold),
        .regWrite(o0_rw), .wd_crypt(o0_wd), .seq_err(o0_err), .cop_valid(o0_valid),
        .cop_ready(1'b1), .cop_mode(o0_mode), .cop_op1(o0_op1), .cop_op2(o0_op2),
        .cop_done(i0_done), .cop_result(i0_result)
    );

    sr_coproc_seq #(.XLEN(XLEN), .MODE_W(MODE_W), .USE_DONE(1), .LATENCY(1),
                    .TIMEOUT(4), .CNT_W(5)) dut1 (
        .clk(clk), .rst(rst), .crypt_instr(i1_instr), .crypt_mode(i1_mode),
        .rd1(i1_rd1), .rd2(i1_rd2), .select_comb_ctrls(o1_sel), .hold(o1_hold),
        .regWrite(o1_rw), .wd_crypt(o1_wd), .seq_err(o1_err), .cop_valid(o1_valid),
        .cop_ready(i1_ready), .cop_mode(o1_mode), .cop_op1(o1_op1), .cop_op2(o1_op2),
        .cop_done(i1_done), .cop_result(i1_result)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic sb_underflow(input string name);
        total++;
        $display("FAIL %s: DUT output with empty scoreboard", name);
    endtask

    task automatic sb_drained(input string name, input int left);
        total++;
        if (left != 0) $display("FAIL %s: %0d entries left, expected 0", name, left);
        else passed++;
    endtask

    typedef struct {
        logic        instr;
        logic [31:0] rd1, rd2, res;
        logic        cap;
        logic        hold, sel, valid, rw;
    } vec_t;

    vec_t tbl[14];

    logic [PL_W-1:0] pq0[$];
    logic [XLEN-1:0] rq0[$];
    logic [XLEN-1:0] rq1[$];
    logic [XLEN-1:0] exp_wd1;

    // One transaction on dut1. Cycle 0 is the decode cycle in IDLE. ready_c/done_c
    // give the cycle each strobe is raised for one cycle (-1 = never). Exactly one
    // of wb_c / err_c is positive and marks the cycle WB or ERR is expected.
    task automatic run1(input string tag, input int ready_c, input int done_c,
                        input logic [31:0] res, input int wb_c, input int err_c);
        logic [PL_W-1:0] exp_pl;
        int end_c;
        end_c = (wb_c > 0) ? wb_c : err_c;
        for (int c = 0; c <= end_c + 1; c++) begin
            @(posedge clk); #1;
            i1_instr  = (c == 0);
            i1_mode   = MODE_W'($urandom);
            i1_rd1    = $urandom;
            i1_rd2    = $urandom;
            i1_ready  = (c == ready_c);
            i1_done   = (c == done_c);
            i1_result = (c == done_c) ? res : $urandom;
            if (c == 0) begin
                exp_pl = {i1_mode, i1_rd1, i1_rd2};
                if (wb_c > 0) rq1.push_back(res);
            end
            @(negedge clk);
            chk({tag, "_hold"}, o1_hold, (c < end_c));
            chk({tag, "_sel"}, o1_sel, (c > end_c));
            chk({tag, "_rw"}, o1_rw, (c == wb_c));
            chk({tag, "_err"}, o1_err, (c == err_c));
            if (c == 1) chk({tag, "_valid_c1"}, o1_valid, 1'b1);
            if (o1_valid) chk({tag, "_payload"}, {o1_mode, o1_op1, o1_op2}, exp_pl);
            if (c == err_c) chk({tag, "_wd_kept"}, o1_wd, exp_wd1);
            if (o1_rw) begin
                if (rq1.size() == 0) sb_underflow({tag, "_wd"});
                else begin
                    exp_wd1 = rq1.pop_front();
                    chk({tag, "_wd"}, o1_wd, exp_wd1);
                end
            end
        end
        sb_drained({tag, "_sb"}, rq1.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          instr rd1            rd2            res            cap hold sel valid rw
        tbl[0]  = '{1'b0, 32'hDEAD0000, 32'hDEAD1000, 32'hBAD00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h00000011, 32'h00000022, 32'hBAD00001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'hDEAD0002, 32'hDEAD1002, 32'hBAD00002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'hDEAD0003, 32'hDEAD1003, 32'h0000ABCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'hDEAD0004, 32'hDEAD1004, 32'hBAD00004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'h00000033, 32'h00000044, 32'hBAD00005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 32'hDEAD0006, 32'hDEAD1006, 32'hBAD00006, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'hDEAD0007, 32'hDEAD1007, 32'h55555555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'hDEAD0008, 32'hDEAD1008, 32'hBAD00008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 32'h00000066, 32'h00000077, 32'hBAD00009, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'hDEAD000A, 32'hDEAD100A, 32'hBAD0000A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 32'hDEAD000B, 32'hDEAD100B, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'hDEAD000C, 32'hDEAD100C, 32'hBAD0000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 32'hDEAD000D, 32'hDEAD100D, 32'hBAD0000D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        i0_instr = 1'b0; i0_done = 1'b0; i0_mode = '0; i0_rd1 = '0; i0_rd2 = '0; i0_result = '0;
        i1_instr = 1'b0; i1_done = 1'b0; i1_ready = 1'b0; i1_mode = '0;
        i1_rd1 = '0; i1_rd2 = '0; i1_result = '0;
        exp_wd1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst0_sel", o0_sel, 1'b1);
        chk("rst0_hold", o0_hold, 1'b0);
        chk("rst0_valid_rw_err", {o0_valid, o0_rw, o0_err}, 3'b000);
        chk("rst0_regs", {o0_mode, o0_op1, o0_op2, o0_wd}, '0);
        chk("rst1_outs", {o1_sel, o1_hold, o1_valid, o1_rw, o1_err}, 5'b10000);
        chk("rst1_regs", {o1_mode, o1_op1, o1_op2, o1_wd}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven fixed-latency run; cop_done is random noise and must be ignored.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            i0_instr  = tbl[i].instr;
            i0_rd1    = tbl[i].rd1;
            i0_rd2    = tbl[i].rd2;
            i0_mode   = MODE_W'($urandom);
            i0_result = tbl[i].res;
            i0_done   = 1'($urandom_range(0, 1));
            if (tbl[i].instr) pq0.push_back({i0_mode, i0_rd1, i0_rd2});
            if (tbl[i].cap) rq0.push_back(tbl[i].res);
            @(negedge clk);
            chk($sformatf("t%0d_hold", i), o0_hold, tbl[i].hold);
            chk($sformatf("t%0d_sel", i), o0_sel, tbl[i].sel);
            chk($sformatf("t%0d_valid", i), o0_valid, tbl[i].valid);
            chk($sformatf("t%0d_rw", i), o0_rw, tbl[i].rw);
            chk($sformatf("t%0d_err", i), o0_err, 1'b0);
            if (o0_valid) begin
                if (pq0.size() == 0) sb_underflow($sformatf("t%0d_payload", i));
                else chk($sformatf("t%0d_payload", i), {o0_mode, o0_op1, o0_op2}, pq0.pop_front());
            end
            if (o0_rw) begin
                if (rq0.size() == 0) sb_underflow($sformatf("t%0d_wd", i));
                else chk($sformatf("t%0d_wd", i), o0_wd, rq0.pop_front());
            end
        end
        sb_drained("t_payload_sb", pq0.size());
        sb_drained("t_wd_sb", rq0.size());

        i0_instr = 1'b0;
        // Ready on the last watchdog ISSUE cycle, done in the second WAIT cycle.
        run1("delayed", 4, 6, 32'hC0FFEE01, 7, -1);
        // Done never comes (a done during IDLE must be ignored): WAIT times out.
        run1("wait_to", 1, 0, 32'h0, -1, 6);
        // Done on the final watchdog cycle wins.
        run1("done_edge", 1, 5, 32'h12345678, 6, -1);
        // Ready never comes; a done strobe during ISSUE is ignored.
        run1("issue_to", -1, 2, 32'h0, -1, 5);
        // Fastest done-terminated transaction.
        run1("fast", 1, 2, 32'h0BADF00D, 3, -1);

        // Reset during WAIT abandons the transaction.
        @(posedge clk); #1;
        i1_instr = 1'b1; i1_rd1 = 32'hAAAA5555; i1_rd2 = 32'h5555AAAA; i1_mode = 21'h1F0F0;
        @(posedge clk); #1;
        i1_instr = 1'b0; i1_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_valid", o1_valid, 1'b1);
        @(posedge clk); #1;
        i1_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_hold_wait", o1_hold, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_outs", {o1_sel, o1_hold, o1_valid, o1_rw, o1_err}, 5'b10000);
        chk("rstmid_regs", {o1_mode, o1_op1, o1_op2, o1_wd}, '0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            i1_done = 1'b1; i1_result = 32'h13579BDF;
            @(negedge clk);
            chk($sformatf("rstmid_late_done%0d", k), {o1_rw, o1_err, o1_hold}, 3'b000);
        end
        @(posedge clk); #1;
        i1_done = 1'b0;
        @(negedge clk);
        chk("rstmid_wd", o1_wd, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
